// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU:
//   - op_e     : 5-bit operation codes (legacy codes preserved)
//   - state_e  : control states of seq_alu
//   - helpers  : op classification (iterative / signedness / remainder)
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [4:0] {
      OP_AND    = 5'b00000,
      OP_OR     = 5'b00001,
      OP_ADD    = 5'b00010,
      OP_XOR    = 5'b00011,
      OP_MUL    = 5'b00100,
      OP_SRL    = 5'b00101,
      OP_SUB    = 5'b00110,
      OP_SRA    = 5'b00111,
      OP_SLT    = 5'b01000,
      OP_SLTU   = 5'b01001,
      OP_SLL    = 5'b01110,
      OP_MULH   = 5'b10000,
      OP_MULHSU = 5'b10001,
      OP_MULHU  = 5'b10010,
      OP_DIV    = 5'b10100,
      OP_DIVU   = 5'b10101,
      OP_REM    = 5'b10110,
      OP_REMU   = 5'b10111
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      MULS,
      DIVS,
      DONE
   } state_e;

   function automatic logic is_mul(input logic [4:0] op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_iterative(input logic [4:0] op);
      return is_mul(op) || is_div(op);
   endfunction

   function automatic logic is_rem(input logic [4:0] op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   // MUL keeps only the low half, which is identical for signed and
   // unsigned operands, so it is handled as unsigned.
   function automatic logic is_signed_a(input logic [4:0] op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_signed_b(input logic [4:0] op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter
// Unsigned iterative core: shift-add multiply or restoring divide, one bit
// per cycle, XLEN cycles per operation.
//   clk, rst    : clock, synchronous active-high reset
//   abort       : drop the operation in flight
//   start       : load magnitudes and begin (mode 0 = multiply, 1 = divide)
//   a_mag/b_mag : multiplier/multiplicand or dividend/divisor
//   done        : high during the final iteration cycle
//   res_hi/lo   : value of the final step; product {hi,lo} or
//                 {remainder, quotient}; valid while done is high
// ---------------------------------------------------------------------------
module muldiv_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            abort,
   input  logic            start,
   input  logic            mode,
   input  logic [XLEN-1:0] a_mag,
   input  logic [XLEN-1:0] b_mag,
   output logic            done,
   output logic [XLEN-1:0] res_hi,
   output logic [XLEN-1:0] res_lo
);

   localparam int CW = $clog2(XLEN);

   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, d_q, d_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            run_q, run_d, mode_q, mode_d;

   logic [XLEN:0]   sum, shifted;
   logic [XLEN-1:0] diff, step_hi, step_lo;
   logic            ge;

   always_comb begin
      // Multiply: add multiplicand when the multiplier LSB is set, then
      // shift the {carry, hi, lo} triple right by one.
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
      // Divide: bring the next dividend bit into the partial remainder and
      // subtract if it fits. The XLEN-bit difference is exact when ge holds.
      shifted = {hi_q, lo_q[XLEN-1]};
      ge      = (shifted >= {1'b0, d_q});
      diff    = shifted[XLEN-1:0] - d_q;
      if (mode_q) begin
         step_hi = ge ? diff : shifted[XLEN-1:0];
         step_lo = {lo_q[XLEN-2:0], ge};
      end else begin
         step_hi = sum[XLEN:1];
         step_lo = {sum[0], lo_q[XLEN-1:1]};
      end
   end

   assign done   = run_q && (cnt_q == '0);
   assign res_hi = step_hi;
   assign res_lo = step_lo;

   always_comb begin
      // NOTE: every _d gets a hold default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      hi_d   = hi_q;
      lo_d   = lo_q;
      d_d    = d_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      mode_d = mode_q;
      if (start) begin
         hi_d   = '0;
         lo_d   = a_mag;
         d_d    = b_mag;
         cnt_d  = CW'(XLEN - 1);
         run_d  = 1'b1;
         mode_d = mode;
      end else if (run_q) begin
         hi_d  = step_hi;
         lo_d  = step_lo;
         cnt_d = cnt_q - 1'b1;
         run_d = (cnt_q != '0);
      end
      if (abort) begin
         run_d = 1'b0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the datapath registers are reset too, so a mid-operation reset
      // leaves no stale partial product or remainder behind.
      if (rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         d_q    <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         mode_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         d_q    <= d_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         mode_q <= mode_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
// Handshaked RV32I/RV32M ALU for EX. Single-cycle ops finish at the accept
// edge; MUL*/DIV*/REM* run XLEN cycles in muldiv_iter, except the division
// fast paths (divide by zero, signed overflow) which finish immediately.
//   clk, rst             : clock, synchronous active-high reset
//   flush                : abort work, drop pending result, block accept
//   in_valid/in_ready    : request handshake (ready only in IDLE)
//   op, in1, in2         : operation code (alu_pkg) and operands
//   out_valid/out_ready  : result handshake (valid only in DONE)
//   result, zero         : registered result and (in1 == in2) of the request
//   busy                 : high while iterating (MULS or DIVS)
// ---------------------------------------------------------------------------
module seq_alu
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] in1,
   input  logic [XLEN-1:0] in2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] alu_simple(input logic [4:0] f_op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
      case (f_op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLL:  return a << b[SHW-1:0];
         OP_SRL:  return a >> b[SHW-1:0];
         OP_SRA:  return $unsigned($signed(a) >>> b[SHW-1:0]);
         OP_SLT:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: return {{(XLEN-1){1'b0}}, a < b};
         default: return '0;
      endcase
   endfunction

   state_e            state_q, state_d;
   logic [4:0]        op_q, op_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              zero_q, zero_d, out_valid_q, out_valid_d;
   logic              busy_q, busy_d, in_ready_q, in_ready_d;
   logic              neg_q, neg_d, rem_neg_q, rem_neg_d;

   logic              accept, sign_a, sign_b, div_zero, div_ovf, fast_path;
   logic              core_start, core_done;
   logic [XLEN-1:0]   a_mag, b_mag, core_hi, core_lo, fast_res;
   logic [XLEN-1:0]   mul_res, div_res, quo, rem;
   logic [2*XLEN-1:0] prod, prod_fix;

   always_comb begin
      accept     = in_valid && in_ready_q && !flush;
      sign_a     = is_signed_a(op) && in1[XLEN-1];
      sign_b     = is_signed_b(op) && in2[XLEN-1];
      // Two's-complement negation of the most negative value yields the
      // correct unsigned magnitude, so no special case is needed here.
      a_mag      = sign_a ? -in1 : in1;
      b_mag      = sign_b ? -in2 : in2;
      div_zero   = (in2 == '0);
      div_ovf    = (op == OP_DIV || op == OP_REM) && (in1 == MOST_NEG) && (in2 == '1);
      fast_path  = is_div(op) && (div_zero || div_ovf);
      fast_res   = is_rem(op) ? (div_zero ? in1 : '0) : (div_zero ? '1 : in1);
      core_start = accept && is_iterative(op) && !fast_path;
   end

   muldiv_iter #(.XLEN(XLEN)) u_core (
      .clk    (clk),
      .rst    (rst),
      .abort  (flush),
      .start  (core_start),
      .mode   (is_div(op)),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .done   (core_done),
      .res_hi (core_hi),
      .res_lo (core_lo)
   );

   // Sign fixup on the final iteration's output.
   always_comb begin
      prod     = {core_hi, core_lo};
      prod_fix = neg_q ? -prod : prod;
      mul_res  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      quo      = neg_q ? -core_lo : core_lo;
      rem      = rem_neg_q ? -core_hi : core_hi;
      div_res  = is_rem(op_q) ? rem : quo;
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      result_d  = result_q;
      zero_d    = zero_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      case (state_q)
         IDLE: if (accept) begin
            op_d      = op;
            zero_d    = (in1 == in2);
            neg_d     = sign_a ^ sign_b;
            rem_neg_d = sign_a;
            if (core_start) begin
               state_d = is_div(op) ? DIVS : MULS;
            end else begin
               state_d  = DONE;
               result_d = is_iterative(op) ? fast_res : alu_simple(op, in1, in2);
            end
         end
         MULS: if (core_done) begin
            state_d  = DONE;
            result_d = mul_res;
         end
         DIVS: if (core_done) begin
            state_d  = DONE;
            result_d = div_res;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // flush wins over completion; visible result and zero are preserved.
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
         zero_d   = zero_q;
      end
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d == MULS) || (state_d == DIVS);
      in_ready_d  = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         neg_q       <= 1'b0;
         rem_neg_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
         neg_q       <= neg_d;
         rem_neg_q   <= rem_neg_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu
// Self-checking bench for seq_alu (XLEN=32 main instance, XLEN=16 instance).
// Expected values come from an arithmetic reference model of the RV32I/M
// rules; latency is measured from the accept edge.
// ---------------------------------------------------------------------------
module tb_seq_alu;

   localparam logic [4:0] C_AND = 5'b00000, C_OR = 5'b00001, C_ADD = 5'b00010;
   localparam logic [4:0] C_XOR = 5'b00011, C_MUL = 5'b00100, C_SRL = 5'b00101;
   localparam logic [4:0] C_SUB = 5'b00110, C_SRA = 5'b00111, C_SLT = 5'b01000;
   localparam logic [4:0] C_SLTU = 5'b01001, C_SLL = 5'b01110;
   localparam logic [4:0] C_MULH = 5'b10000, C_MULHSU = 5'b10001, C_MULHU = 5'b10010;
   localparam logic [4:0] C_DIV = 5'b10100, C_DIVU = 5'b10101;
   localparam logic [4:0] C_REM = 5'b10110, C_REMU = 5'b10111;

   localparam logic [4:0] CODES [20] = '{
      C_AND, C_OR, C_ADD, C_XOR, C_MUL, C_SRL, C_SUB, C_SRA, C_SLT, C_SLTU,
      C_SLL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU,
      5'b01010, 5'b11111};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [4:0]  op = '0;
   logic [31:0] in1 = '0, in2 = '0;
   logic        in_ready, out_valid, zero, busy;
   logic [31:0] result;

   logic        flush16 = 1'b0, in_valid16 = 1'b0, out_ready16 = 1'b1;
   logic [4:0]  op16 = '0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        in_ready16, out_valid16, zero16, busy16;
   logic [15:0] result16;

   int errors = 0;
   int checks = 0;

   seq_alu #(.XLEN(32)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .busy(busy));

   seq_alu #(.XLEN(16)) u_dut16 (
      .clk(clk), .rst(rst), .flush(flush16), .in_valid(in_valid16), .in_ready(in_ready16),
      .op(op16), .in1(a16), .in2(b16), .out_valid(out_valid16), .out_ready(out_ready16),
      .result(result16), .zero(zero16), .busy(busy16));

   // ---------------- reference model (RV32I/M arithmetic) ----------------
   function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      int          sa, sb;
      longint      p;
      logic [63:0] u;
      logic [4:0]  sh;
      sa = a;
      sb = b;
      sh = b[4:0];
      case (o)
         C_AND:  return a & b;
         C_OR:   return a | b;
         C_XOR:  return a ^ b;
         C_ADD:  return a + b;
         C_SUB:  return a - b;
         C_SLL:  return a << sh;
         C_SRL:  return a >> sh;
         C_SRA:  return 32'(sa >>> sh);
         C_SLT:  return {31'b0, sa < sb};
         C_SLTU: return {31'b0, a < b};
         C_MUL:  begin u = 64'(a) * 64'(b); return u[31:0]; end
         C_MULH: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
         C_MULHSU: begin p = longint'(sa) * longint'(b); return p[63:32]; end
         C_MULHU: begin u = 64'(a) * 64'(b); return u[63:32]; end
         C_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         C_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         C_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         C_REMU: return (b == 0) ? a : a % b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [4:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
      bit dv, ml;
      dv = o inside {C_DIV, C_DIVU, C_REM, C_REMU};
      ml = o inside {C_MUL, C_MULH, C_MULHSU, C_MULHU};
      if (dv && (b == 0 || ((o == C_DIV || o == C_REM) && a == 32'h8000_0000 &&
                            b == 32'hFFFF_FFFF)))
         return 1;
      return (dv || ml) ? 33 : 1;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Issue one request with out_ready high, measure latency, check outputs.
   task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string name);
      logic [31:0] want;
      int          want_lat, lat;
      bit          bad_busy;
      want     = ref_result(o, a, b);
      want_lat = ref_latency(o, a, b);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready: got %b want 1", name, in_ready);
      end
      op = o; in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      bad_busy = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (busy !== ((want_lat > 1) && (lat < want_lat))) bad_busy = 1'b1;
      end while (out_valid !== 1'b1 && lat < 200);
      checks++;
      if (lat != want_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
      end
      checks++;
      if (result !== want) begin
         errors++;
         $display("FAIL %s result: got %h want %h", name, result, want);
      end
      checks++;
      if (zero !== (a == b)) begin
         errors++;
         $display("FAIL %s zero: got %b want %b", name, zero, a == b);
      end
      checks++;
      if (bad_busy) begin
         errors++;
         $display("FAIL %s busy profile: got wrong level before result, want high on cycles 1..%0d",
                  name, want_lat - 1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({out_valid, busy, zero, in_ready} !== 4'b0001 || result !== 32'h0) begin
         errors++;
         $display("FAIL reset: got v=%b b=%b z=%b r=%b res=%h want 0 0 0 1 0",
                  out_valid, busy, zero, in_ready, result);
      end
      checks++;
      if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || result16 !== 16'h0) begin
         errors++;
         $display("FAIL reset16: got r=%b v=%b res=%h want 1 0 0", in_ready16, out_valid16, result16);
      end
   endtask

   task automatic test_legacy();
      do_op(C_ADD, 32'h7FFF_FFFF, 32'h1, "add_wrap");
      do_op(C_SUB, 32'd5, 32'd7, "sub_neg");
      do_op(C_SLL, 32'h1, 32'd35, "sll_amount");
      do_op(C_OR, 32'h1234, 32'h1234, "zero_flag");
      do_op(C_SRA, 32'h8000_0010, 32'd4, "sra_sign");
      do_op(C_SLT, 32'hFFFF_FFFF, 32'h1, "slt_neg");
      do_op(C_SLTU, 32'hFFFF_FFFF, 32'h1, "sltu_big");
      do_op(5'b11111, 32'h55, 32'h66, "undefined_op");
   endtask

   task automatic test_muldiv();
      do_op(C_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1");
      do_op(C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
      do_op(C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1");
      do_op(C_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
      do_op(C_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
      do_op(C_REM, 32'hFFFF_FFF9, 32'd2, "rem_neg");
      do_op(C_DIVU, 32'd100, 32'd0, "divu_by_zero");
      do_op(C_REM, 32'd100, 32'd0, "rem_by_zero");
      do_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      do_op(C_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         do_op(CODES[$urandom_range(0, 19)], pick_operand(), pick_operand(), "random");
      end
   endtask

   task automatic test_backpressure();
      int  lat;
      bit  bad_res, bad_rdy, bad_val, bad_zero;
      @(negedge clk);
      out_ready = 1'b0;
      op = C_DIVU; in1 = 32'd9; in2 = 32'd4; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (out_valid !== 1'b1 && lat < 200);
      checks++;
      if (lat != 33) begin
         errors++;
         $display("FAIL bp latency: got %0d want 33", lat);
      end
      {bad_res, bad_rdy, bad_val, bad_zero} = '0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         if (result !== 32'd2) bad_res = 1'b1;
         if (in_ready !== 1'b0) bad_rdy = 1'b1;
         if (out_valid !== 1'b1) bad_val = 1'b1;
         if (zero !== 1'b0) bad_zero = 1'b1;
         op = C_ADD; in1 = 32'd1; in2 = 32'd1; in_valid = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (bad_res || result !== 32'd2) begin
         errors++;
         $display("FAIL bp hold result: got %h want 00000002", result);
      end
      checks++;
      if (bad_rdy) begin
         errors++;
         $display("FAIL bp in_ready: got 1 during hold want 0");
      end
      checks++;
      if (bad_val || bad_zero) begin
         errors++;
         $display("FAIL bp out_valid/zero: got val_drop=%b zero_change=%b want 0 0", bad_val, bad_zero);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp release: got r=%b v=%b want 1 0", in_ready, out_valid);
      end
      do_op(C_ADD, 32'd5, 32'd5, "bp_next");
   endtask

   task automatic test_flush();
      bit seen;
      do_op(C_ADD, 32'h10, 32'h20, "pre_flush");
      @(negedge clk);
      op = C_MUL; in1 = 32'd3; in2 = 32'd5; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_mul state: got r=%b b=%b v=%b want 1 0 0", in_ready, busy, out_valid);
      end
      checks++;
      if (result !== 32'h30) begin
         errors++;
         $display("FAIL flush_mul result kept: got %h want 00000030", result);
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL flush_mul late valid: got out_valid=1 want 0");
      end
      // Request in the same cycle as flush must be dropped.
      op = C_ADD; in1 = 32'd7; in2 = 32'd7; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      flush = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen || result !== 32'h30 || zero !== 1'b0) begin
         errors++;
         $display("FAIL flush_accept: got v_seen=%b res=%h z=%b want 0 00000030 0", seen, result, zero);
      end
      do_op(C_ADD, 32'd1, 32'd2, "post_flush");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      op = C_DIV; in1 = 32'hFFFF_FFF9; in2 = 32'd2; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got v=%b res=%h r=%b b=%b want 0 00000000 1 0",
                  out_valid, result, in_ready, busy);
      end
      do_op(C_DIV, 32'hFFFF_FFF9, 32'd2, "div_after_reset");
   endtask

   task automatic do_op16(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] want, input int want_lat, input string name);
      int lat;
      @(negedge clk);
      op16 = o; a16 = a; b16 = b; in_valid16 = 1'b1;
      @(posedge clk);
      #1 in_valid16 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (out_valid16 !== 1'b1 && lat < 100);
      checks++;
      if (lat != want_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
      end
      checks++;
      if (result16 !== want) begin
         errors++;
         $display("FAIL %s result: got %h want %h", name, result16, want);
      end
   endtask

   task automatic test_xlen16();
      do_op16(C_MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17, "x16_mulhu");
      do_op16(C_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 17, "x16_mul");
      do_op16(C_MULH, 16'hFFFF, 16'hFFFF, 16'h0000, 17, "x16_mulh");
      do_op16(C_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 17, "x16_div");
      do_op16(C_REMU, 16'd100, 16'd7, 16'd2, 17, "x16_remu");
      do_op16(C_DIV, 16'h8000, 16'hFFFF, 16'h8000, 1, "x16_div_ovf");
      do_op16(C_SRA, 16'h8000, 16'h0013, 16'hF000, 1, "x16_sra");
   endtask

   initial begin
      test_reset();
      test_legacy();
      test_muldiv();
      test_random();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_xlen16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked ALU for the rv32i core.
- Replaces the purely combinational ALU.
- Adds the full RV32I integer op set and RV32M multiply/divide, using iterative multi-cycle multiply/divide.
- Sits in EX. The decode stage drives the request; writeback consumes the result through a valid/ready handshake. The pipeline flush aborts in-flight work.

Parameters:
- XLEN, 32, datapath width; power of two, at least 8.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  abort current operation, drop any pending result.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- op  in  5  operation code (alu_pkg).
- in1  in  XLEN  operand A.
- in2  in  XLEN  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  registered result.
- zero  out  1  registered (in1==in2) of the accepted operands.
- busy  out  1  high in MUL or DIV states.

Behaviour:
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, busy=0, in_ready=1 (after the reset edge).
- Accept rule: in_valid && in_ready && !flush captures op, in1, in2 and zero=(in1==in2).
- Op codes, with legacy codes kept:
  - 00000 AND, 00001 OR, 00010 ADD, 00110 SUB, 01110 SLL.
  - 00011 XOR, 00101 SRL, 00111 SRA, 01000 SLT, 01001 SLTU.
  - 00100 MUL, 10000 MULH, 10001 MULHSU, 10010 MULHU.
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - Any other code returns result 0 with single-cycle latency.
- Shifts use in2[SHW-1:0] only. SRA sign-extends. SLT/SLTU return 0 or 1, zero-extended. ADD/SUB wrap modulo 2^XLEN.
- State machine:
  - IDLE: on accept, single-cycle op -> DONE (result computed at the accept edge).
  - IDLE: MUL* -> MULS; DIV/REM* -> DIVS, unless a fast-path case applies, which goes -> DONE.
  - MULS: shift-add on operand magnitudes, one bit per cycle, counter from XLEN-1 down to 0. At count 0, apply sign fixup, load result, go -> DONE.
  - MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits; signedness is per the RV32M spec (MULHSU: in1 signed, in2 unsigned).
  - DIVS: restoring division on magnitudes, XLEN iterations, same counter. Final cycle applies signs: quotient sign = sign(in1)^sign(in2), remainder sign = sign(in1). Load result, go -> DONE.
  - DONE: out_valid=1 and result held stable. out_ready -> IDLE next cycle. No back-to-back accept in the cycle the result drains; in_ready stays low in DONE.
- Latency, with the accept edge as cycle 0:
  - Single-cycle ops: out_valid high from cycle 1.
  - Iterative ops: out_valid high from cycle XLEN+1.
- Division fast paths (-> DONE directly, latency 1):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> in1.
  - Signed overflow (in1 = most negative, in2 = -1): DIV -> in1; REM -> 0.
- flush has priority over everything except rst.
  - Next state is IDLE and out_valid=0 next cycle.
  - result and zero keep their last value.
  - A request presented in the same cycle as flush is not accepted.
- rst in any state, including mid-iteration, behaves exactly as at power-on; the counter is cleared.
- Holding out_ready low in DONE holds result indefinitely; inputs are ignored.

Decomposition:
- alu_pkg holds:
  - the op code localparams/enum;
  - the state enum (IDLE, MULS, DIVS, DONE);
  - the is_iterative(op) and is_signed_a/b(op) helper functions.
- Sub-module muldiv_iter: XLEN-parametrised shift-add/restoring core.
  - Inputs: start, mode, magnitudes.
  - Outputs: done pulse, 2*XLEN product or quotient/remainder.
  - seq_alu owns the handshake, sign fixup, fast paths and flush.

Test Plan:
- Legacy ops: ADD 0x7FFFFFFF+1 -> 0x80000000, out_valid at cycle 1. SUB 5-7 -> 0xFFFFFFFE. SLL 1<<35 -> 0x8 (amount 3). zero=1 when in1=in2=0x1234.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU -> 0xFFFFFFFE; MUL -> 0x00000001; out_valid at cycle 33 and busy high on cycles 1-32.
- DIV -7/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF. DIVU 100/0 -> 0xFFFFFFFF, latency 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after DIVU 9/4 -> result stays 2, in_ready=0 throughout, a new in_valid is ignored; release -> IDLE, then the next request is accepted.
- flush at cycle 10 of a MUL -> out_valid never rises, in_ready=1 at cycle 11. Also flush together with in_valid -> nothing accepted.
- rst asserted at cycle 5 of a DIV -> next cycle out_valid=0, result=0, in_ready=1. Also run an XLEN=16 regression: MULHU 0xFFFF*0xFFFF -> 0xFFFE, latency 17.
